// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered one-hot AHB bus arbiter with round-robin
// rotation and a bounded hold time per owner.
// Optional feature: define AHB_ARB_LOCK_EN to add the per-manager Lock port.
// A locked owner is never released, not even by the hold-time limit.
module round_robin_arbiter #(
  parameter int NUM_MGR  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_MGR-1:0]         Request,
  input  logic                       HREADY,
`ifdef AHB_ARB_LOCK_EN
  input  logic [NUM_MGR-1:0]         Lock,
`endif
  output logic [NUM_MGR-1:0]         Grant,
  output logic [$clog2(NUM_MGR)-1:0] GrantIdx,
  output logic                       Busy,
  output logic                       Switch
);
  localparam int IW = $clog2(NUM_MGR);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MGR - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state_q, state_n;
  logic [NUM_MGR-1:0] grant_q, grant_n;
  logic [IW-1:0]      idx_q, idx_n;
  logic [IW-1:0]      last_q, last_n;
  logic [HW-1:0]      hold_q, hold_n;
  logic               sw_q, sw_n;

  logic [IW-1:0]      win;
  logic               own_req, others, owner_lock, release_ok;

  // The first requester after 'l', wrapping; 'l' itself is checked last.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_MGR-1:0] r,
                                            input logic [IW-1:0] l);
    logic [IW-1:0] w;
    logic          f;
    int            j;
    w = l;
    f = 1'b0;
    for (int k = 1; k <= NUM_MGR; k++) begin
      j = (int'(l) + k) % NUM_MGR;
      if (!f && r[j]) begin
        f = 1'b1;
        w = IW'(j);
      end
    end
    return w;
  endfunction

  assign win     = rr_pick(Request, last_q);
  assign own_req = |(Request & grant_q);
  assign others  = |(Request & ~grant_q);

`ifdef AHB_ARB_LOCK_EN
  assign owner_lock = (state_q == OWNED) && Lock[idx_q];
`else
  assign owner_lock = 1'b0;
`endif

  // The owner leaves when it stops requesting, or when its hold time is
  // used up and someone else is waiting.
  assign release_ok = HREADY && !owner_lock &&
                      (!own_req || ((hold_q == HMAX) && others));

  // State register: reset wins over every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      hold_q  <= hold_n;
      sw_q    <= sw_n;
    end
  end

  // Next-state logic: arbitrate only on HREADY cycles.
  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    idx_n   = idx_q;
    last_n  = last_q;
    hold_n  = hold_q;
    sw_n    = 1'b0;
    case (state_q)
      IDLE: begin
        hold_n = '0;
        if (HREADY && |Request) begin
          state_n = OWNED;
          idx_n   = win;
          grant_n = {{(NUM_MGR-1){1'b0}}, 1'b1} << win;
          last_n  = win;
          sw_n    = 1'b1;
        end
      end
      OWNED: begin
        if (release_ok) begin
          hold_n = '0;
          sw_n   = 1'b1;
          if (|Request) begin
            idx_n   = win;
            grant_n = {{(NUM_MGR-1){1'b0}}, 1'b1} << win;
            last_n  = win;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            idx_n   = '0;
          end
        end else if (HREADY) begin
          // When the owner is the only requester, it keeps the grant and
          // its hold count restarts. Otherwise the count saturates.
          if (hold_q == HMAX)
            hold_n = (own_req && !others) ? '0 : HMAX;
          else
            hold_n = hold_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic: all outputs come straight from registers.
  always_comb begin
    Grant    = grant_q;
    GrantIdx = idx_q;
    Busy     = (state_q == OWNED);
    Switch   = sw_q;
  end
endmodule
